// File: rtl/mult_sequencer.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, signed operands handled
// by multiplying magnitudes and negating the 2*WIDTH-bit product in a final FIX cycle.
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    // Lower accumulator half doubles as the multiplier shift register.
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   r_prod_hi;
    logic [WIDTH-1:0]   r_prod_lo;

    logic               w_accept;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    // Negating the most-negative value yields the same bit pattern, which is the
    // correct unsigned magnitude.
    assign w_mag_a = (is_signed & op_a[WIDTH-1]) ? (-op_a) : op_a;
    assign w_mag_b = (is_signed & op_b[WIDTH-1]) ? (-op_b) : op_b;

    assign w_addend = r_acc_lo[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = {1'b0, r_acc_hi} + w_addend;
    assign w_acc    = {r_acc_hi, r_acc_lo};
    assign w_prod   = r_neg ? (-w_acc) : w_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_mcand  <= w_mag_a;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_mag_b;
                        r_cnt    <= CW'(WIDTH);
                        r_neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_prod_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_prod_lo <= w_prod[WIDTH-1:0];
                    r_state   <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == S_RUN) | (r_state == S_FIX);
    assign done    = (r_state == S_DONE);
    assign stall   = ~reset & (busy | w_accept);
    assign prod_hi = r_prod_hi;
    assign prod_lo = r_prod_lo;

endmodule
